// File: rtl/ram_cycle_ctrl_pkg.sv
// Shared types and constants for the 68030 RAM bank cycle sequencer.
package ram_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WSTRB,
    WAIT,
    ACK
  } state_t;

  localparam logic [1:0] DSACK_IDLE = 2'b11;
  localparam logic [1:0] DSACK_32   = 2'b00;

  localparam int unsigned DEFAULT_WAIT_STATES = 1;
  localparam int unsigned DEFAULT_CNT_W       = 4;

endpackage

// File: rtl/ram_cycle_ctrl_if.sv
// CPU strobe inputs and RAM strobe / DSACK outputs of the RAM bank sequencer.
interface ram_cycle_ctrl_if;

  logic       cpuASn;
  logic       cpuDSn;
  logic       cpuRWn;
  logic       ramSELn;
  logic [3:0] byteSELn;
  logic       ramCEn;
  logic       ramOEn;
  logic [3:0] ramWEn;
  logic [1:0] cpuDSACKn;

  modport master (
    output cpuASn, cpuDSn, cpuRWn, ramSELn, byteSELn,
    input  ramCEn, ramOEn, ramWEn, cpuDSACKn
  );

  modport slave (
    input  cpuASn, cpuDSn, cpuRWn, ramSELn, byteSELn,
    output ramCEn, ramOEn, ramWEn, cpuDSACKn
  );

endinterface

// File: rtl/ram_cycle_ctrl_wait_counter.sv
// Wait-state down-counter: load, decrement, and a flag that marks the final wait edge.
module ram_wait_counter #(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             tc
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  assign tc = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/ram_cycle_ctrl.sv
// RAM bank bus-cycle sequencer: drives CE/OE/WE strobes and terminates with a 32-bit DSACK.
module ram_cycle_ctrl
  import ram_ctrl_pkg::*;
#(
  parameter int unsigned WAIT_STATES = DEFAULT_WAIT_STATES,
  parameter int unsigned CNT_W       = DEFAULT_CNT_W
) (
  input  logic             sysClk,
  input  logic             sysRst,
  ram_cycle_ctrl_if.slave  bus
);

  state_t     state_q, state_d;
  logic       ce_q, ce_d;
  logic       oe_q, oe_d;
  logic [3:0] we_q, we_d;
  logic [1:0] ack_q, ack_d;
  logic       cnt_load, cnt_dec, cnt_tc;

  ram_wait_counter #(
    .CNT_W (CNT_W)
  ) u_wait_counter (
    .clk      (sysClk),
    .rst      (sysRst),
    .load     (cnt_load),
    .load_val (CNT_W'(WAIT_STATES)),
    .dec      (cnt_dec),
    .tc       (cnt_tc)
  );

  always_ff @(posedge sysClk) begin
    if (sysRst) begin
      state_q <= IDLE;
      ce_q    <= 1'b1;
      oe_q    <= 1'b1;
      we_q    <= '1;
      ack_q   <= DSACK_IDLE;
    end else begin
      state_q <= state_d;
      ce_q    <= ce_d;
      oe_q    <= oe_d;
      we_q    <= we_d;
      ack_q   <= ack_d;
    end
  end

  // Outputs are registered, so each branch computes the value they take after this edge.
  always_comb begin
    state_d  = state_q;
    ce_d     = ce_q;
    oe_d     = oe_q;
    we_d     = we_q;
    ack_d    = ack_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;

    unique case (state_q)
      IDLE: begin
        ce_d  = 1'b1;
        oe_d  = 1'b1;
        we_d  = '1;
        ack_d = DSACK_IDLE;
        if (!bus.cpuASn && !bus.ramSELn) begin
          ce_d = 1'b0;
          if (bus.cpuRWn) begin
            oe_d     = 1'b0;
            cnt_load = 1'b1;
            if (WAIT_STATES == 0) begin
              state_d = ACK;
              ack_d   = DSACK_32;
            end else begin
              state_d = WAIT;
            end
          end else begin
            state_d = WSTRB;
          end
        end
      end

      WSTRB: begin
        if (bus.cpuASn) begin
          state_d = IDLE;
          ce_d    = 1'b1;
          oe_d    = 1'b1;
          we_d    = '1;
          ack_d   = DSACK_IDLE;
        end else if (!bus.cpuDSn) begin
          we_d     = bus.byteSELn;
          cnt_load = 1'b1;
          if (WAIT_STATES == 0) begin
            state_d = ACK;
            ack_d   = DSACK_32;
          end else begin
            state_d = WAIT;
          end
        end
      end

      // An AS release during the wait takes priority over a terminal count on the same edge.
      WAIT: begin
        if (bus.cpuASn) begin
          state_d = IDLE;
          ce_d    = 1'b1;
          oe_d    = 1'b1;
          we_d    = '1;
          ack_d   = DSACK_IDLE;
        end else begin
          cnt_dec = 1'b1;
          if (cnt_tc) begin
            state_d = ACK;
            ack_d   = DSACK_32;
          end
        end
      end

      ACK: begin
        if (bus.cpuASn) begin
          state_d = IDLE;
          ce_d    = 1'b1;
          oe_d    = 1'b1;
          we_d    = '1;
          ack_d   = DSACK_IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.ramCEn    = ce_q;
  assign bus.ramOEn    = oe_q;
  assign bus.ramWEn    = we_q;
  assign bus.cpuDSACKn = ack_q;

endmodule

// File: tb/tb_ram_cycle_ctrl.sv
// Scoreboard bench: three sequencers (0, 1 and 3 wait states) share one CPU stimulus stream.
module tb_ram_cycle_ctrl;

  localparam int unsigned WS0 = 0;
  localparam int unsigned WS1 = 1;
  localparam int unsigned WS2 = 3;

  typedef struct packed {
    logic [2:0]      ce;
    logic [2:0]      oe;
    logic [2:0][3:0] we;
    logic [2:0][1:0] ack;
  } exp_t;

  typedef struct {
    bit          busy;
    bit          rd;
    bit          strobed;
    int unsigned tref;
    logic [3:0]  lanes;
  } txn_t;

  logic       clk;
  logic       rst;
  logic       asn, dsn, rwn, seln;
  logic [3:0] bsel;

  ram_cycle_ctrl_if bus0 ();
  ram_cycle_ctrl_if bus1 ();
  ram_cycle_ctrl_if bus2 ();

  assign bus0.cpuASn = asn;  assign bus0.cpuDSn = dsn;  assign bus0.cpuRWn = rwn;
  assign bus0.ramSELn = seln; assign bus0.byteSELn = bsel;
  assign bus1.cpuASn = asn;  assign bus1.cpuDSn = dsn;  assign bus1.cpuRWn = rwn;
  assign bus1.ramSELn = seln; assign bus1.byteSELn = bsel;
  assign bus2.cpuASn = asn;  assign bus2.cpuDSn = dsn;  assign bus2.cpuRWn = rwn;
  assign bus2.ramSELn = seln; assign bus2.byteSELn = bsel;

  ram_cycle_ctrl #(.WAIT_STATES(WS0), .CNT_W(4)) dut0 (.sysClk(clk), .sysRst(rst), .bus(bus0));
  ram_cycle_ctrl #(.WAIT_STATES(WS1), .CNT_W(4)) dut1 (.sysClk(clk), .sysRst(rst), .bus(bus1));
  ram_cycle_ctrl #(.WAIT_STATES(WS2), .CNT_W(4)) dut2 (.sysClk(clk), .sysRst(rst), .bus(bus2));

  logic [2:0]      a_ce, a_oe;
  logic [2:0][3:0] a_we;
  logic [2:0][1:0] a_ack;

  assign a_ce  = {bus2.ramCEn, bus1.ramCEn, bus0.ramCEn};
  assign a_oe  = {bus2.ramOEn, bus1.ramOEn, bus0.ramOEn};
  assign a_we  = {bus2.ramWEn, bus1.ramWEn, bus0.ramWEn};
  assign a_ack = {bus2.cpuDSACKn, bus1.cpuDSACKn, bus0.cpuDSACKn};

  exp_t        q[$];
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned edge_no  = 0;
  int unsigned ws_tab[3] = '{WS0, WS1, WS2};
  txn_t        m[3];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Transaction-level reference: a cycle is open from the AS+SEL sample until AS is seen high;
  // DSACK is due once WAIT_STATES edges have passed since the strobe sample (AS for reads, DS for writes).
  initial begin
    exp_t e;
    for (int d = 0; d < 3; d++) m[d] = '{busy: 0, rd: 0, strobed: 0, tref: 0, lanes: 4'hF};
    forever begin
      @(posedge clk);
      for (int d = 0; d < 3; d++) begin
        if (rst) begin
          m[d].busy = 0;
        end else if (!m[d].busy) begin
          if (!asn && !seln) begin
            m[d].busy    = 1;
            m[d].rd      = rwn;
            m[d].strobed = rwn;
            m[d].tref    = edge_no;
            m[d].lanes   = 4'hF;
          end
        end else if (asn) begin
          m[d].busy = 0;
        end else if (!m[d].rd && !m[d].strobed && !dsn) begin
          m[d].strobed = 1;
          m[d].tref    = edge_no;
          m[d].lanes   = bsel;
        end
        if (!m[d].busy) begin
          e.ce[d] = 1'b1; e.oe[d] = 1'b1; e.we[d] = 4'hF; e.ack[d] = 2'b11;
        end else begin
          e.ce[d]  = 1'b0;
          e.oe[d]  = m[d].rd ? 1'b0 : 1'b1;
          e.we[d]  = m[d].rd ? 4'hF : m[d].lanes;
          e.ack[d] = (m[d].strobed && (edge_no - m[d].tref >= ws_tab[d])) ? 2'b00 : 2'b11;
        end
      end
      q.push_back(e);
      edge_no++;
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        for (int d = 0; d < 3; d++) begin
          n_checks++;
          if ({a_ce[d], a_oe[d], a_we[d], a_ack[d]} !== {e.ce[d], e.oe[d], e.we[d], e.ack[d]}) begin
            n_fail++;
            $display("FAIL outputs dut%0d edge %0d: got ce=%b oe=%b we=%b dsack=%b, expected ce=%b oe=%b we=%b dsack=%b",
                     d, edge_no - 1, a_ce[d], a_oe[d], a_we[d], a_ack[d],
                     e.ce[d], e.oe[d], e.we[d], e.ack[d]);
          end
        end
      end
    end
  end

  task automatic cyc(input logic a, input logic ds, input logic rw, input logic sel,
                     input logic [3:0] b, input logic r, input int unsigned n);
    asn = a; dsn = ds; rwn = rw; seln = sel; bsel = b; rst = r;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    asn = 1; dsn = 1; rwn = 1; seln = 1; bsel = 4'hF; rst = 1;
    cyc(1, 1, 1, 1, 4'hF, 1, 2);
    cyc(1, 1, 1, 1, 4'hF, 0, 1);
    // read held for several edges, then release
    cyc(0, 1, 1, 0, 4'hF, 0, 5);
    cyc(1, 1, 1, 0, 4'hF, 0, 1);
    // write: DS one edge after AS, lanes change after DS sample
    cyc(0, 1, 0, 0, 4'b1100, 0, 1);
    cyc(0, 0, 0, 0, 4'b1100, 0, 1);
    cyc(0, 0, 0, 1, 4'b0000, 0, 4);
    cyc(1, 1, 1, 1, 4'hF, 0, 1);
    // write with no lanes selected
    cyc(0, 0, 0, 0, 4'hF, 0, 5);
    cyc(1, 1, 1, 1, 4'hF, 0, 1);
    // abort a read mid-wait
    cyc(0, 1, 1, 0, 4'hF, 0, 2);
    cyc(1, 1, 1, 0, 4'hF, 0, 2);
    // abort a write before DS
    cyc(0, 1, 0, 0, 4'h0, 0, 2);
    cyc(1, 1, 1, 1, 4'hF, 0, 1);
    // non-hit
    cyc(0, 1, 1, 1, 4'hF, 0, 3);
    cyc(1, 1, 1, 1, 4'hF, 0, 1);
    // reset while acknowledged, AS still low afterwards
    cyc(0, 1, 1, 0, 4'hF, 0, 5);
    cyc(0, 1, 1, 0, 4'hF, 1, 1);
    cyc(0, 1, 1, 0, 4'hF, 0, 5);
    cyc(1, 1, 1, 1, 4'hF, 0, 1);
    // back-to-back reads with a single AS-high edge between them
    cyc(0, 1, 1, 0, 4'hF, 0, 5);
    cyc(1, 1, 1, 0, 4'hF, 0, 1);
    cyc(0, 1, 1, 0, 4'hF, 0, 5);
    cyc(1, 1, 1, 1, 4'hF, 0, 1);
    for (int i = 0; i < 1500; i++) begin
      cyc($urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
          $urandom_range(0, 4) == 0, 4'($urandom), $urandom_range(0, 59) == 0, 1);
    end
    cyc(1, 1, 1, 1, 4'hF, 0, 2);
    @(negedge clk);
    #1;
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_cycle_ctrl.md
Name: ram_cycle_ctrl

Overview:
Bus-cycle sequencer for the 68030 RAM bank. It sits directly downstream of the byte/word lane-select decoder. It consumes the active-low lane selects plus the CPU strobes and drives the RAM chip-enable, output-enable and per-lane write strobes. It terminates each cycle with a 32-bit-port DSACK after a parameterised number of wait states.

Parameters:
WAIT_STATES, 1, clock cycles inserted between strobe assertion and DSACK assertion (0..15)
CNT_W, 4, width of the wait-state counter; must satisfy 2**CNT_W > WAIT_STATES

Ports:
sysClk  input  1  system clock; all CPU inputs are synchronous to it
sysRst  input  1  synchronous reset, active-high
cpuASn  input  1  CPU address strobe, active low
cpuDSn  input  1  CPU data strobe, active low
cpuRWn  input  1  1 = read, 0 = write
ramSELn  input  1  address-decode hit for the RAM bank, active low
byteSELn  input  4  write lane selects from the lane decoder, active low, [3] = D31:24
ramCEn  output  1  RAM chip enable, active low
ramOEn  output  1  RAM output enable, active low
ramWEn  output  4  per-lane RAM write enables, active low
cpuDSACKn  output  2  cycle termination; 2'b00 = 32-bit port ack, 2'b11 = idle

Behaviour:
- Clocking and reset: one clock (sysClk), reset synchronous active-high (sysRst). All outputs are registered.
- Reset values: ramCEn=1, ramOEn=1, ramWEn=4'hF, cpuDSACKn=2'b11, state=IDLE, counter=0. Reset asserted mid-cycle forces these values at the next edge regardless of state.
- States: IDLE, WSTRB, WAIT, ACK.
- IDLE: at an edge where cpuASn=0 and ramSELn=0:
  - Read (cpuRWn=1): assert ramCEn and ramOEn, load counter=WAIT_STATES, go to WAIT. If WAIT_STATES=0, go straight to ACK and assert DSACK at the same edge.
  - Write (cpuRWn=0): assert ramCEn, go to WSTRB.
  - Otherwise remain in IDLE with outputs idle.
- WSTRB: at an edge where cpuDSn=0:
  - Drive ramWEn[i]=byteSELn[i], captured at that edge and held for the rest of the cycle.
  - Load counter=WAIT_STATES, go to WAIT. If WAIT_STATES=0, go to ACK and assert DSACK at that edge.
- WAIT: decrement counter each edge. At the edge where the counter equals 1, go to ACK and drive cpuDSACKn=2'b00.
- ACK: hold all strobes and DSACK. At the first edge with cpuASn=1, deassert everything and return to IDLE.
- Read latency: DSACK is asserted exactly WAIT_STATES edges after the edge that sampled AS+SEL (same edge if 0).
- Write latency: the same count, measured from the edge that sampled DS.
- Abort: cpuASn=1 sampled in WSTRB or WAIT returns to IDLE with all outputs deasserted at that edge. No DSACK is issued.
- Back-to-back cycles: IDLE needs at least one edge with AS high between cycles; ACK never re-enters WAIT directly.
- ramSELn is sampled only in IDLE. Changes during a cycle are ignored.
- byteSELn=4'hF on a write, i.e. the decoder asserted no lane: the cycle still completes with DSACK and no WE strobes.
- ramOEn is never asserted on a write cycle. ramWEn is never asserted on a read cycle.
- Invariant: cpuDSACKn is 2'b00 or 2'b11 only.

Decomposition:
- Shared package ram_ctrl_pkg:
  - state enum (IDLE, WSTRB, WAIT, ACK)
  - DSACK encodings DSACK_IDLE=2'b11, DSACK_32=2'b00
  - default WAIT_STATES constant
- Sub-module ram_wait_counter (load/decrement/terminal-count flag, CNT_W wide). The FSM and output registers remain in ram_cycle_ctrl.

Test Plan:
- Read, WAIT_STATES=1: AS=0, SEL=0, RWn=1 at edge 0 -> CE=OE=0 after edge 0, DSACK=00 after edge 1. AS=1 at edge 4 -> all outputs idle after edge 4.
- Write, WAIT_STATES=2, byteSELn=4'b1100, DS low one edge after AS -> WEn=1100 after the DS edge, DSACK=00 two edges later, OE stays 1 throughout.
- WAIT_STATES=0 read -> DSACK=00 on the same edge CE/OE assert. WAIT_STATES=0 write -> DSACK on the DS-sampled edge.
- Abort: AS rises while in WAIT with counter=2 -> all outputs idle at that edge, DSACK never asserted, FSM back in IDLE.
- Non-hit and sync reset: ramSELn=1 with AS=0 -> outputs stay idle. Separately, sysRst=1 during ACK -> CE=1, WEn=F, DSACK=11 at the next edge.
- Back-to-back: two reads separated by a single AS-high edge -> both are acknowledged, and DSACK deasserts for at least one edge between them.
